// File: rtl/palabra_mayor_nin.sv
// Pipelined N-input max/min selector. Returns the winning word, its lowest index and a tie flag.
// A single pipeline enable moves every stage together under valid/ready backpressure.
module palabra_mayor_nin #(
  parameter  int unsigned WIDTH  = 4,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned LEVELS = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [LEVELS-1:0]       out_index,
  output logic                    out_tie
);

  localparam int unsigned STAGES = LEVELS + 1;

  // Stage 0 holds the captured sample; stage l holds NUM_IN>>l tournament candidates.
  logic              vld_q  [STAGES];
  logic              vld_d  [STAGES];
  logic              mode_q [STAGES];
  logic              mode_d [STAGES];
  logic [WIDTH-1:0]  val_q  [STAGES][NUM_IN];
  logic [WIDTH-1:0]  val_d  [STAGES][NUM_IN];
  logic [LEVELS-1:0] idx_q  [STAGES][NUM_IN];
  logic [LEVELS-1:0] idx_d  [STAGES][NUM_IN];
  logic              tie_q  [STAGES][NUM_IN];
  logic              tie_d  [STAGES][NUM_IN];

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [LEVELS-1:0] out_index_q, out_index_d;
  logic              out_tie_q,   out_tie_d;

  logic              advance;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = reset & advance;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_tie   = out_tie_q;

  // Right candidate displaces the left only on a strict win, so equal values keep the lower index.
  function automatic logic right_wins(input logic mode, input logic [WIDTH-1:0] lval,
                                      input logic [WIDTH-1:0] rval);
    return mode ? (rval < lval) : (rval > lval);
  endfunction

  always_comb begin
    vld_d       = vld_q;
    mode_d      = mode_q;
    val_d       = val_q;
    idx_d       = idx_q;
    tie_d       = tie_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_tie_d   = out_tie_q;

    if (advance) begin
      vld_d[0]  = in_valid;
      mode_d[0] = in_mode;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        val_d[0][i] = in_data[i*WIDTH +: WIDTH];
        idx_d[0][i] = LEVELS'(i);
        tie_d[0][i] = 1'b0;
      end

      for (int l = 1; l < int'(STAGES); l++) begin
        vld_d[l]  = vld_q[l-1];
        mode_d[l] = mode_q[l-1];
        for (int j = 0; j < int'(NUM_IN >> l); j++) begin
          if (right_wins(mode_q[l-1], val_q[l-1][2*j], val_q[l-1][2*j+1])) begin
            val_d[l][j] = val_q[l-1][2*j+1];
            idx_d[l][j] = idx_q[l-1][2*j+1];
            tie_d[l][j] = tie_q[l-1][2*j+1];
          end else begin
            val_d[l][j] = val_q[l-1][2*j];
            idx_d[l][j] = idx_q[l-1][2*j];
            tie_d[l][j] = (val_q[l-1][2*j] == val_q[l-1][2*j+1]) | tie_q[l-1][2*j];
          end
        end
      end

      // Output registers only load real results so they keep the last one across bubbles.
      out_valid_d = vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        out_data_d  = val_q[LEVELS][0];
        out_index_d = idx_q[LEVELS][0];
        out_tie_d   = tie_q[LEVELS][0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < int'(STAGES); s++) begin
        vld_q[s]  <= 1'b0;
        mode_q[s] <= 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
          val_q[s][i] <= '0;
          idx_q[s][i] <= '0;
          tie_q[s][i] <= 1'b0;
        end
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_tie_q   <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      mode_q      <= mode_d;
      val_q       <= val_d;
      idx_q       <= idx_d;
      tie_q       <= tie_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_tie_q   <= out_tie_d;
    end
  end

endmodule

// File: tb/tb_palabra_mayor_nin.sv
// Scoreboard bench for palabra_mayor_nin: driver pushes expected results, a monitor pops on handshake.
module tb_palabra_mayor_nin;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned LEVELS = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [LEVELS-1:0]       out_index;
  logic                    out_tie;

  typedef struct {
    logic [3:0] data;
    logic [1:0] idx;
    logic       tie;
    bit         chk_lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   lat_en = 1'b1;
  bit   front_seen = 1'b0;
  int   rdy_mode = 0;

  palabra_mayor_nin #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_tie   (out_tie)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sink: always ready, random 50%, or stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input logic [3:0] w0, input logic [3:0] w1,
                                     input logic [3:0] w2, input logic [3:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Hold the sample until in_ready is seen before an edge; the expected result is queued then.
  task automatic send(input logic [15:0] d, input logic m, input logic [3:0] ed,
                      input logic [1:0] ei, input logic et);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{ed, ei, et, lat_en, cyc + 1});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 300 cycles");
    end
  endtask

  // Reference: linear scan with strict comparison keeps the lowest index among equals.
  task automatic send_rand();
    logic [15:0] d;
    logic        m;
    logic [3:0]  best;
    logic [1:0]  bi;
    int          cnt;
    d    = 16'($urandom);
    m    = 1'($urandom_range(0, 1));
    best = d[3:0];
    bi   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (m ? (d[i*4 +: 4] < best) : (d[i*4 +: 4] > best)) begin
        best = d[i*4 +: 4];
        bi   = 2'(i);
      end
    end
    cnt = 0;
    for (int i = 0; i < 4; i++) if (d[i*4 +: 4] == best) cnt++;
    send(d, m, best, bi, cnt > 1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk({"drain_", tag}, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result must match the queue head; it is popped on handshake.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got data=%0d idx=%0d, expected no result", out_data, out_index);
      end else begin
        e = q[0];
        chk("out_data",  int'(out_data),  int'(e.data));
        chk("out_index", int'(out_index), int'(e.idx));
        chk("out_tie",   int'(out_tie),   int'(e.tie));
        if (e.chk_lat && !front_seen) chk("latency", cyc - e.acc, 3);
        front_seen = 1'b1;
        if (out_ready) begin
          e = q.pop_front();
          front_seen = 1'b0;
        end else begin
          chk("in_ready_stall", int'(in_ready), 0);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_tie",   int'(out_tie),   0);
    chk("rst_in_ready",  int'(in_ready),  0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed, back-to-back, hand-computed results.
    send(pk(3, 9, 5, 1),     1'b0, 4'd9,  2'd1, 1'b0);
    send(pk(3, 9, 5, 1),     1'b1, 4'd1,  2'd3, 1'b0);
    send(pk(7, 2, 7, 7),     1'b0, 4'd7,  2'd0, 1'b1);
    send(pk(7, 2, 7, 7),     1'b1, 4'd2,  2'd1, 1'b0);
    send(pk(15, 15, 15, 15), 1'b0, 4'd15, 2'd0, 1'b1);
    send(pk(15, 15, 15, 15), 1'b1, 4'd15, 2'd0, 1'b1);
    send(pk(4, 8, 8, 2),     1'b0, 4'd8,  2'd1, 1'b1);
    send(pk(4, 8, 8, 2),     1'b1, 4'd2,  2'd3, 1'b0);
    send(pk(1, 1, 0, 0),     1'b1, 4'd0,  2'd2, 1'b1);
    send(pk(0, 0, 0, 14),    1'b0, 4'd14, 2'd3, 1'b0);
    in_valid = 1'b0;
    drain("directed");

    for (int i = 0; i < 16; i++) send_rand();
    in_valid = 1'b0;
    drain("stream");

    // Fill the pipeline, then stall the sink for 5 cycles.
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain("backpressure");

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) send_rand();
    in_valid = 1'b0;
    drain("random_ready");
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Two results visible/pending and three samples in flight, then asynchronous reset.
    lat_en = 1'b1;
    for (int i = 0; i < 5; i++) send_rand();
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data",  int'(out_data),  0);
    chk("midrst_out_index", int'(out_index), 0);
    chk("midrst_out_tie",   int'(out_tie),   0);
    chk("midrst_in_ready",  int'(in_ready),  0);
    q.delete();
    front_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_out_valid", int'(out_valid), 0);

    send(pk(3, 9, 5, 1), 1'b0, 4'd9, 2'd1, 1'b0);
    in_valid = 1'b0;
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
